// File: rtl/lbp_pkg.sv
// -----------------------------------------------------------------------------
// lbp_pkg
//   Shared definitions for the LBP gray-memory read arbiter:
//   default address/data widths for a 128x128 8-bit image, the arbiter state
//   encoding, and the rotating-priority pick function used by lbp_rr_pick.
//   Optional feature macro used by the arbiter: BURST_LOCK_EN.
// -----------------------------------------------------------------------------
package lbp_pkg;

  localparam int IMG_W      = 128;
  localparam int LBP_ADDR_W = 2 * $clog2(IMG_W);
  localparam int LBP_DATA_W = 8;
  localparam int MAX_REQ    = 4;

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_LOCK  = 2'd1,
    ST_DONE  = 2'd2
  } lbp_state_e;

  // Rotating priority: the first set request strictly after ptr (modulo n)
  // wins; ptr itself is the lowest priority. Returns one-hot, or zero.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [1:0]         ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] g;
    logic               found;
    int unsigned        idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      if (k <= n) begin
        idx = ({30'b0, ptr} + k) % n;
        if (!found && req[idx[1:0]]) begin
          g[idx[1:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/lbp_rr_pick.sv
// -----------------------------------------------------------------------------
// lbp_rr_pick
//   Combinational round-robin selector.
//   req_i : request vector (NUM_REQ)
//   ptr_i : index of the last winner (lowest priority this cycle)
//   gnt_o : one-hot grant, zero when no request is set
// -----------------------------------------------------------------------------
module lbp_rr_pick
  import lbp_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [MAX_REQ-1:0] req_ext;
  logic [1:0]         ptr_ext;
  logic [MAX_REQ-1:0] pick;
  logic               unused_pick;

  always_comb begin
    req_ext                 = '0;
    req_ext[NUM_REQ-1:0]    = req_i;
    ptr_ext                 = '0;
    ptr_ext[PTR_W-1:0]      = ptr_i;
  end

  assign pick        = rr_pick(req_ext, ptr_ext, NUM_REQ);
  assign gnt_o       = pick[NUM_REQ-1:0];
  assign unused_pick = ^pick;

endmodule

// File: rtl/lbp_rd_arbiter.sv
// -----------------------------------------------------------------------------
// lbp_rd_arbiter
//   Shares the single gray-image memory read port among NUM_REQ LBP engines
//   with round-robin arbitration (one read per cycle) and routes each returned
//   pixel back to its issuer through a one-cycle tag pipeline. Also merges the
//   per-engine finish flags into a single sticky finish.
//
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     req/req_addr    per-engine read request (held until granted) / address
//     gnt             combinational one-hot grant
//     rd_data         returned pixel (passthrough of gray_data)
//     rd_valid        one-hot owner of rd_data this cycle (registered)
//     eng_finish      per-engine finish pulse or level
//     gray_addr/req   registered memory address / read request
//     gray_ready      memory ready; no grant while low
//     gray_data       memory data, valid one cycle after gray_req
//     finish          registered, all engines finished
//     req_lock        (BURST_LOCK_EN only) per-engine burst lock request
//
//   Optional feature macro: BURST_LOCK_EN (adds req_lock and the LOCK state).
// -----------------------------------------------------------------------------
module lbp_rd_arbiter
  import lbp_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = LBP_ADDR_W,
  parameter int DATA_W  = LBP_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
`ifdef BURST_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        rd_valid,
  input  logic [NUM_REQ-1:0]        eng_finish,
  output logic [ADDR_W-1:0]         gray_addr,
  output logic                      gray_req,
  input  logic                      gray_ready,
  input  logic [DATA_W-1:0]         gray_data,
  output logic                      finish
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  lbp_state_e          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  fin_latch_q, fin_latch_d;
  logic                gray_req_q;
  logic [ADDR_W-1:0]   gray_addr_q;
  logic [PTR_W-1:0]    tag_q;
  logic [NUM_REQ-1:0]  rd_valid_q;
  logic                finish_q;

  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  win_oh;
  logic [PTR_W-1:0]    win_idx;
  logic                any_gnt;
  logic [ADDR_W-1:0]   win_addr;

  // Eligibility uses the registered latches, so a finish arriving together
  // with a request does not block that request.
  always_comb begin
    eligible = req & ~fin_latch_q;
`ifdef BURST_LOCK_EN
    // While locked, only the lock owner (the last winner) may be granted.
    if (state_q == ST_LOCK) eligible = eligible & (NUM_REQ'(1) << ptr_q);
`endif
    if (state_q == ST_DONE || !gray_ready) eligible = '0;
  end

  lbp_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req_i (eligible),
    .ptr_i (ptr_q),
    .gnt_o (win_oh)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) win_idx = PTR_W'(i);
    end
  end

  assign any_gnt     = |win_oh;
  assign win_addr    = req_addr[win_idx*ADDR_W +: ADDR_W];
  assign fin_latch_d = fin_latch_q | eng_finish;
  assign ptr_d       = any_gnt ? win_idx : ptr_q;

  // finish and DONE follow the cycle in which the last latch gets set.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SERVE: begin
        if (&fin_latch_d) state_d = ST_DONE;
`ifdef BURST_LOCK_EN
        else if (any_gnt && req_lock[win_idx]) state_d = ST_LOCK;
`endif
      end
`ifdef BURST_LOCK_EN
      ST_LOCK: begin
        if (&fin_latch_d) state_d = ST_DONE;
        else if (eng_finish[ptr_q]) state_d = ST_SERVE;
        else if (any_gnt && !req_lock[win_idx]) state_d = ST_SERVE;
      end
`endif
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_SERVE;
    endcase
  end

  // Issue and return stages; reset drops any read still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SERVE;
      ptr_q       <= PTR_W'(NUM_REQ - 1);
      fin_latch_q <= '0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      rd_valid_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      fin_latch_q <= fin_latch_d;
      gray_req_q  <= any_gnt;
      if (any_gnt) gray_addr_q <= win_addr;
      rd_valid_q  <= gray_req_q ? (NUM_REQ'(1) << tag_q) : '0;
      finish_q    <= finish_q | (&fin_latch_d);
    end
  end

  // Tag only qualifies data when gray_req_q is set, so it needs no reset.
  always_ff @(posedge clk) begin
    tag_q <= win_idx;
  end

  assign gnt       = win_oh;
  assign gray_req  = gray_req_q;
  assign gray_addr = gray_addr_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = gray_data;
  assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_rd_arbiter.sv
module tb_lbp_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [27:0] req_addr;
`ifdef BURST_LOCK_EN
  logic [1:0]  req_lock;
`endif
  logic [1:0]  gnt;
  logic [7:0]  rd_data;
  logic [1:0]  rd_valid;
  logic [1:0]  eng_finish;
  logic [13:0] gray_addr;
  logic        gray_req;
  logic        gray_ready;
  logic [7:0]  gray_data = 8'h00;
  logic        finish;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lbp_rd_arbiter #(.NUM_REQ(2), .ADDR_W(14), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
`ifdef BURST_LOCK_EN
    .req_lock   (req_lock),
`endif
    .gnt        (gnt),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .eng_finish (eng_finish),
    .gray_addr  (gray_addr),
    .gray_req   (gray_req),
    .gray_ready (gray_ready),
    .gray_data  (gray_data),
    .finish     (finish)
  );

  // Memory model: data = low byte + high bits of the address, one cycle later.
  always @(posedge clk) begin
    if (gray_req) gray_data <= gray_addr[7:0] + {2'b00, gray_addr[13:8]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; req_addr = '0; eng_finish = 2'b00; gray_ready = 1'b1;
`ifdef BURST_LOCK_EN
    req_lock = 2'b00;
`endif
    tick(); tick();
    reset = 1'b0;
    #2;
    chk("rst_gray_req", 32'(gray_req), 32'h0);
    chk("rst_gray_addr", 32'(gray_addr), 32'h0);
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_finish", 32'(finish), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);

    // Test 1: both engines requesting, grants alternate starting at engine 0
    tick(); req = 2'b11; req_addr = {14'h2081, 14'h0081}; #2;
    chk("t1_gnt0", 32'(gnt), 32'h1);
    tick(); #2;
    chk("t1_gnt1", 32'(gnt), 32'h2);
    chk("t1_greq1", 32'(gray_req), 32'h1);
    chk("t1_gaddr1", 32'(gray_addr), 32'h0081);
    tick(); #2;
    chk("t1_gnt2", 32'(gnt), 32'h1);
    chk("t1_gaddr2", 32'(gray_addr), 32'h2081);
    chk("t1_rdv2", 32'(rd_valid), 32'h1);
    chk("t1_rdd2", 32'(rd_data), 32'h81);
    tick(); #2;
    chk("t1_gnt3", 32'(gnt), 32'h2);
    chk("t1_gaddr3", 32'(gray_addr), 32'h0081);
    chk("t1_rdv3", 32'(rd_valid), 32'h2);
    chk("t1_rdd3", 32'(rd_data), 32'hA1);
    tick(); req = 2'b00; #2;
    chk("t1_gnt4", 32'(gnt), 32'h0);
    chk("t1_greq4", 32'(gray_req), 32'h1);
    chk("t1_rdv4", 32'(rd_valid), 32'h1);
    tick(); #2;
    chk("t1_greq5", 32'(gray_req), 32'h0);
    chk("t1_gaddr5_hold", 32'(gray_addr), 32'h2081);
    chk("t1_rdv5", 32'(rd_valid), 32'h2);
    tick(); #2;
    chk("t1_rdv6", 32'(rd_valid), 32'h0);

    // Test 2: engine 1 alone for 9 cycles, address changes each cycle
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k < 9) begin
        req = 2'b10;
        req_addr[27:14] = 14'(14'h0100 + k);
      end else begin
        req = 2'b00;
      end
      #2;
      chk($sformatf("t2_gnt%0d", k), 32'(gnt), (k < 9) ? 32'h2 : 32'h0);
      chk($sformatf("t2_rdv%0d", k), 32'(rd_valid), (k >= 2 && k <= 10) ? 32'h2 : 32'h0);
      if (k >= 2 && k <= 10) chk($sformatf("t2_rdd%0d", k), 32'(rd_data), 32'(k - 1));
    end

    // Test 3: memory stall; first grant after release goes past the last winner
    tick(); req = 2'b11; req_addr = {14'h2081, 14'h0081}; #2;
    chk("t3_gnt_pre", 32'(gnt), 32'h1);
    for (int j = 0; j < 3; j++) begin
      tick(); gray_ready = 1'b0; #2;
      chk($sformatf("t3_gnt_stall%0d", j), 32'(gnt), 32'h0);
      chk($sformatf("t3_greq_stall%0d", j), 32'(gray_req), (j == 0) ? 32'h1 : 32'h0);
      if (j == 1) begin
        chk("t3_rdv_inflight", 32'(rd_valid), 32'h1);
        chk("t3_rdd_inflight", 32'(rd_data), 32'h81);
      end
    end
    tick(); gray_ready = 1'b1; #2;
    chk("t3_gnt_release", 32'(gnt), 32'h2);
    tick(); #2;
    chk("t3_gnt_next", 32'(gnt), 32'h1);

    // Test 4: finish handling
    tick(); eng_finish = 2'b01; #2;
    chk("t4_gnt_fin0", 32'(gnt), 32'h2);
    for (int j = 1; j < 5; j++) begin
      tick(); eng_finish = 2'b00; #2;
      chk($sformatf("t4_gnt_only1_%0d", j), 32'(gnt), 32'h2);
    end
    tick(); eng_finish = 2'b10; #2;
    chk("t4_gnt_fin1_same", 32'(gnt), 32'h2);
    chk("t4_finish_pre", 32'(finish), 32'h0);
    tick(); eng_finish = 2'b00; #2;
    chk("t4_finish", 32'(finish), 32'h1);
    chk("t4_gnt_done", 32'(gnt), 32'h0);
    chk("t4_greq_last", 32'(gray_req), 32'h1);
    tick(); #2;
    chk("t4_gnt_done2", 32'(gnt), 32'h0);
    chk("t4_finish2", 32'(finish), 32'h1);
    chk("t4_greq_done", 32'(gray_req), 32'h0);
    chk("t4_rdv_last", 32'(rd_valid), 32'h2);

    // Test 5: reset right after a grant drops the in-flight read
    tick(); reset = 1'b1; req = 2'b00;
    tick(); reset = 1'b0; req = 2'b11; #2;
    chk("t5_gnt", 32'(gnt), 32'h1);
    tick(); reset = 1'b1; req = 2'b00; #2;
    chk("t5_greq_rst", 32'(gray_req), 32'h0);
    chk("t5_rdv_rst", 32'(rd_valid), 32'h0);
    tick(); reset = 1'b0; #2;
    chk("t5_rdv_after", 32'(rd_valid), 32'h0);
    chk("t5_greq_after", 32'(gray_req), 32'h0);
    chk("t5_gaddr_after", 32'(gray_addr), 32'h0);
    chk("t5_finish_after", 32'(finish), 32'h0);
    tick(); req = 2'b11; #2;
    chk("t5_gnt_first", 32'(gnt), 32'h1);

`ifdef BURST_LOCK_EN
    // Test 6: engine 0 locks for 9 grants while engine 1 waits
    tick(); reset = 1'b1; req = 2'b00;
    tick(); reset = 1'b0; req = 2'b11;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      req_lock = (k < 8) ? 2'b01 : 2'b00;
      #2;
      chk($sformatf("t6_gnt_lock%0d", k), 32'(gnt), 32'h1);
    end
    tick(); req_lock = 2'b00; #2;
    chk("t6_gnt_after", 32'(gnt), 32'h2);
`endif

    tick(); req = 2'b00;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lbp_rd_arbiter.md
Name: lbp_rd_arbiter

Overview:
Shares the single gray-image memory read port (gray_addr/gray_req/gray_ready/gray_data) among NUM_REQ LBP window engines, so that several engines can process image stripes in parallel.
- Arbitration is round-robin, one read per cycle; each returned pixel is routed back to its issuer by a tag pipeline.
- The block also aggregates the per-engine finish flags into the top-level finish.

Parameters:
NUM_REQ, 2, number of LBP engine requesters (2..4)
ADDR_W, 14, gray memory address width (128x128 image)
DATA_W, 8, gray pixel width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-engine read request; held until granted
req_addr  in  NUM_REQ*ADDR_W  per-engine read address; slice i belongs to engine i
gnt  out  NUM_REQ  combinational one-hot grant; request accepted this cycle
rd_data  out  DATA_W  returned pixel, shared by all engines
rd_valid  out  NUM_REQ  one-hot; rd_data belongs to engine i this cycle
eng_finish  in  NUM_REQ  per-engine finish pulse or level
gray_addr  out  ADDR_W  registered memory address
gray_req  out  1  registered memory read request
gray_ready  in  1  memory ready; no grant is issued while low
gray_data  in  DATA_W  memory data, valid one cycle after gray_req
finish  out  1  registered; all engines finished

Behaviour:
- Reset values: gray_req=0, gray_addr=0, rd_valid=0, finish=0, RR pointer=NUM_REQ-1 (so engine 0 has first priority), finish latches cleared, state=SERVE. Asserting reset mid-operation drops all in-flight tags; no rd_valid is issued for them.
- States:
  - SERVE: normal arbitration.
  - LOCK: exists only with the optional feature.
  - DONE: entered the cycle after all finish latches are set; absorbing until reset.
- Arbitration in cycle t, SERVE only:
  - Eligible set = req & ~fin_latch.
  - If gray_ready=1 and the eligible set is non-empty, the winner w is the first eligible index after the RR pointer, modulo NUM_REQ.
  - gnt[w]=1 in cycle t (combinational), and the RR pointer becomes w at t+1.
- Issue: at t+1, gray_req=1 and gray_addr=req_addr[w]; a 1-cycle tag register holds w.
  - If there is no grant at t, gray_req=0 at t+1 and gray_addr holds its last value.
- Return: at t+2, rd_valid[w]=1 and rd_data=gray_data (passthrough, unregistered). The rd_valid pipeline is registered.
- Latency:
  - Request to gnt: 0 cycles.
  - Grant to rd_valid: 2 cycles.
  - Throughput: 1 read/cycle with back-to-back grants.
- The requester may change req_addr the cycle after gnt. A deasserted req is never granted.
- Stall: gray_ready=0 in cycle t gives no gnt at t; a read issued at t-1 still returns at t+1.
- Finish handling:
  - eng_finish[i]=1 sets sticky fin_latch[i]; finished engines become ineligible.
  - finish goes to 1 one cycle after fin_latch becomes all-ones, then stays 1.
  - In DONE, gnt=0 and gray_req=0; reads already in flight still return.
- Simultaneous events: if eng_finish[i] and req[i] arrive in the same cycle, the request is still granted and finishing takes effect next cycle.

Optional Feature:
Macro BURST_LOCK_EN.
- When defined:
  - Adds input port req_lock (NUM_REQ).
  - If winner w has req_lock[w]=1 at grant, the state moves to LOCK, and only w is eligible until a cycle in which w is granted with req_lock[w]=0; the state then returns to SERVE.
  - The purpose is 9-pixel window bursts without interleaving.
  - In LOCK, if w deasserts req, no grant is issued and the lock is held.
  - A finish from w in LOCK releases the lock.
- When undefined: no req_lock port, no LOCK state, pure per-read round-robin.

Decomposition:
- Package lbp_pkg: ADDR_W/DATA_W defaults, IMG_W=128, state encoding (SERVE, LOCK, DONE), and a rr_pick function for rotating priority.
- One sub-module, lbp_rr_pick: combinational round-robin priority selector (req, ptr) -> one-hot gnt.

Test Plan:
1. Reset then req=2'b11, addr0=0x0081, addr1=0x2081, gray_ready=1 held -> grants alternate 0,1,0,1. gray_addr=0x0081 at t+1, 0x2081 at t+2. rd_valid 01 at t+2, 10 at t+3.
2. Only req[1]=1 for 9 cycles -> 9 consecutive gnt[1]; rd_valid[1] for 9 consecutive cycles, 2 cycles delayed.
3. gray_ready=0 for 3 cycles with both requesting -> gnt=0 and gray_req=0 after one cycle. On release, the first grant goes to the engine after the last winner.
4. eng_finish[0] pulse, then eng_finish[1] 5 cycles later -> engine 0 never granted again. finish=1 exactly one cycle after the second pulse; gnt stays 0 afterwards.
5. Reset asserted the cycle after a grant -> rd_valid stays 0. Outputs return to reset values. Engine 0 wins first after release.
6. (BURST_LOCK_EN) Engine 0 holds lock for 9 grants while engine 1 requests -> 9 consecutive gnt[0], then gnt[1] immediately after.
